// File: rtl/game_sequencer.sv
// game_sequencer: turn FSM, paddle, moving block and scores for the VGA dodge demo.
// Every game register advances only on the internal frame tick.
// Optional build macro GAME_SPEEDUP_EN: when defined, the block step grows with the
// active player's score (1 + score/3, capped at 4); otherwise the step is BLOCK_STEP.
module game_sequencer #(
   parameter int TICK_DIV     = 2097152,
   parameter int WIN_SCORE    = 10,
   parameter int PLAYER_Y_RST = 240,
   parameter int PLAYER_STEP  = 2,
   parameter int PLAYER_X     = 224,
   parameter int PLAYER_HALF  = 10,
   parameter int Y_MIN        = 10,
   parameter int Y_MAX        = 469,
   parameter int BLOCK_W      = 20,
   parameter int BLOCK_H      = 16,
   parameter int BLOCK_STEP   = 1,
   parameter int X_MAX        = 640,
   parameter int BLOCK_Y_BASE = 112
) (
   input  logic       board_clk,
   input  logic       reset,
   input  logic       start,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [9:0] player_y,
   output logic [9:0] block_x,
   output logic [9:0] block_y,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic [1:0] state,
   output logic       tick,
   output logic       hit
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      QI      = 2'b00,
      QGAME_1 = 2'b01,
      QGAME_2 = 2'b10,
      QDONE   = 2'b11
   } state_t;

   state_t          cur_st, nxt_st;
   logic [PW-1:0]   pre_cnt;
   logic [7:0]      lfsr;

   logic [9:0]      py_d, bx_d, by_d;
   logic [3:0]      p1_d, p2_d;

   logic [10:0]     bx11, by11, py11, step11;
   logic [3:0]      act_score, score_inc;
   logic            in_game, collide, wrap, win;
   logic [10:0]     py_dn, py_up;

   assign state = cur_st;
   assign tick  = (pre_cnt == PW'(TICK_DIV - 1));

   // Frame prescaler: free-running 0..TICK_DIV-1
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset)     pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + 1'b1;
   end

   // Lane LFSR, x^8+x^6+x^5+x^4+1, steps every clock so lanes depend on timing
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) lfsr <= 8'h01;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   // Shared game-condition terms, evaluated on the current (pre-tick) registers
   always_comb begin
      bx11      = {1'b0, block_x};
      by11      = {1'b0, block_y};
      py11      = {1'b0, player_y};
      in_game   = (cur_st == QGAME_1) || (cur_st == QGAME_2);
      act_score = (cur_st == QGAME_2) ? p2_score : p1_score;
`ifdef GAME_SPEEDUP_EN
      step11    = 11'd1 + 11'(act_score / 4'd3);
      if (step11 > 11'd4) step11 = 11'd4;
`else
      step11    = 11'(BLOCK_STEP);
`endif
      collide   = (bx11 + 11'(BLOCK_W - 1) >= 11'(PLAYER_X)) &&
                  (bx11 <= 11'(PLAYER_X + 31)) &&
                  (by11 + 11'(BLOCK_H - 1) >= py11 - 11'(PLAYER_HALF)) &&
                  (by11 <= py11 + 11'(PLAYER_HALF));
      wrap      = (bx11 + step11 >= 11'(X_MAX));
      // saturating increment: scores never pass WIN_SCORE
      score_inc = (act_score >= 4'(WIN_SCORE)) ? 4'(WIN_SCORE) : act_score + 4'd1;
      win       = (score_inc == 4'(WIN_SCORE));
      py_dn     = py11 + 11'(PLAYER_STEP);
      py_up     = (py11 < 11'(Y_MIN + PLAYER_STEP)) ? 11'(Y_MIN) : py11 - 11'(PLAYER_STEP);
   end

   // State register
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) cur_st <= QI;
      else       cur_st <= nxt_st;
   end

   // Next-state: transitions only on tick
   always_comb begin
      nxt_st = cur_st;
      if (tick) begin
         case (cur_st)
            QI:      if (start) nxt_st = QGAME_1;
            QGAME_1: if (collide) nxt_st = QGAME_2;
                     else if (wrap && win) nxt_st = QDONE;
            QGAME_2: if (collide) nxt_st = QGAME_1;
                     else if (wrap && win) nxt_st = QDONE;
            QDONE:   if (!start) nxt_st = QI;
            default: nxt_st = QI;
         endcase
      end
   end

   // Datapath next values and hit pulse; a launch re-centres paddle and picks a new lane
   always_comb begin
      py_d = player_y;
      bx_d = block_x;
      by_d = block_y;
      p1_d = p1_score;
      p2_d = p2_score;
      hit  = 1'b0;
      if (tick) begin
         if (cur_st == QI && start) begin
            bx_d = '0;
            by_d = 10'(BLOCK_Y_BASE) + {2'b00, lfsr};
            py_d = 10'(PLAYER_Y_RST);
            p1_d = '0;
            p2_d = '0;
         end else if (in_game) begin
            if (collide) begin
               hit  = 1'b1;
               bx_d = '0;
               by_d = 10'(BLOCK_Y_BASE) + {2'b00, lfsr};
               py_d = 10'(PLAYER_Y_RST);
            end else if (wrap) begin
               if (cur_st == QGAME_2) p2_d = score_inc;
               else                   p1_d = score_inc;
               if (!win) begin
                  bx_d = '0;
                  by_d = 10'(BLOCK_Y_BASE) + {2'b00, lfsr};
                  py_d = 10'(PLAYER_Y_RST);
               end
            end else begin
               bx_d = block_x + step11[9:0];
               if (btn_down && !btn_up)
                  py_d = (py_dn > 11'(Y_MAX)) ? 10'(Y_MAX) : py_dn[9:0];
               else if (btn_up && !btn_down)
                  py_d = py_up[9:0];
            end
         end
      end
   end

   // Game registers
   always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
         player_y <= 10'(PLAYER_Y_RST);
         block_x  <= '0;
         block_y  <= 10'(BLOCK_Y_BASE);
         p1_score <= '0;
         p2_score <= '0;
      end else begin
         player_y <= py_d;
         block_x  <= bx_d;
         block_y  <= by_d;
         p1_score <= p1_d;
         p2_score <= p2_d;
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed table plus hand-written rounds (dodge, clamp, collision, win).
module tb_game_sequencer;

   logic       board_clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [9:0] player_y, block_x, block_y;
   logic [3:0] p1_score, p2_score;
   logic [1:0] state;
   logic       tick, hit;

   int tests = 0;
   int fails = 0;

   game_sequencer #(.TICK_DIV(4)) dut (
      .board_clk(board_clk), .reset(reset), .start(start),
      .btn_up(btn_up), .btn_down(btn_down),
      .player_y(player_y), .block_x(block_x), .block_y(block_y),
      .p1_score(p1_score), .p2_score(p2_score), .state(state),
      .tick(tick), .hit(hit)
   );

   always #5 board_clk = ~board_clk;

   // Reference lane generator: taps 8,6,5,4, seeded 8'h01, steps every clock
   logic [7:0] lfsr_m, lfsr_used;
   always @(posedge board_clk or posedge reset) begin
      if (reset) begin
         lfsr_m    <= 8'h01;
         lfsr_used <= 8'h01;
      end else begin
         lfsr_used <= lfsr_m;
         lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
      end
   end

   typedef struct {
      logic       st, up, dn, launch;
      logic [1:0] e_state;
      int         e_bx, e_py;
   } vec_t;

   vec_t tbl [10];

   logic [9:0] pre_bx, pre_py;
   logic       saw_hit, post_hit;
   int         exp_by;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance to the next tick cycle, capture pre-tick values, then move one cycle past it
   task automatic step_tick();
      int n = 0;
      @(negedge board_clk);
      while (!tick && n < 16) begin
         @(negedge board_clk);
         n++;
      end
      if (!tick) chk("tick_timeout", 0, 1);
      saw_hit = hit;
      pre_bx  = block_x;
      pre_py  = player_y;
      @(negedge board_clk);
      post_hit = hit;
   endtask

   // Run ticks until the block stops advancing by one (wrap, win freeze or collision)
   task automatic run_round(input logic up, input logic dn, output logic [9:0] py400);
      int n = 0;
      btn_up   = up;
      btn_down = dn;
      py400    = '0;
      do begin
         step_tick();
         if (pre_bx == 10'd399) py400 = player_y;
         n++;
      end while (block_x == pre_bx + 10'd1 && n < 800);
      if (n >= 800) chk("round_timeout", 0, 1);
      chk("wrap_from_639", pre_bx, 639);
   endtask

   initial begin
      logic [9:0] py400;
      int         tgt, n;

      tbl[0] = '{st:1'b0, up:1'b0, dn:1'b0, launch:1'b0, e_state:2'b00, e_bx:0, e_py:240};
      tbl[1] = '{st:1'b1, up:1'b0, dn:1'b0, launch:1'b1, e_state:2'b01, e_bx:0, e_py:240};
      tbl[2] = '{st:1'b0, up:1'b0, dn:1'b0, launch:1'b0, e_state:2'b01, e_bx:1, e_py:240};
      tbl[3] = '{st:1'b0, up:1'b0, dn:1'b1, launch:1'b0, e_state:2'b01, e_bx:2, e_py:242};
      tbl[4] = '{st:1'b0, up:1'b1, dn:1'b0, launch:1'b0, e_state:2'b01, e_bx:3, e_py:240};
      tbl[5] = '{st:1'b0, up:1'b1, dn:1'b1, launch:1'b0, e_state:2'b01, e_bx:4, e_py:240};
      tbl[6] = '{st:1'b0, up:1'b1, dn:1'b0, launch:1'b0, e_state:2'b01, e_bx:5, e_py:238};
      tbl[7] = '{st:1'b0, up:1'b0, dn:1'b0, launch:1'b0, e_state:2'b01, e_bx:6, e_py:238};
      tbl[8] = '{st:1'b1, up:1'b1, dn:1'b1, launch:1'b0, e_state:2'b01, e_bx:7, e_py:238};
      tbl[9] = '{st:1'b0, up:1'b0, dn:1'b1, launch:1'b0, e_state:2'b01, e_bx:8, e_py:240};

      // Reset values while reset is held
      repeat (3) @(negedge board_clk);
      chk("rst_player_y", player_y, 240);
      chk("rst_block_x", block_x, 0);
      chk("rst_block_y", block_y, 112);
      chk("rst_state", state, 0);
      chk("rst_p1", p1_score, 0);
      chk("rst_p2", p2_score, 0);
      chk("rst_tick", tick, 0);
      chk("rst_hit", hit, 0);
      reset = 1'b0;

      // Table: start, first moves, button combinations, start ignored in game
      exp_by = 112;
      for (int i = 0; i < 10; i++) begin
         start    = tbl[i].st;
         btn_up   = tbl[i].up;
         btn_down = tbl[i].dn;
         step_tick();
         if (tbl[i].launch) exp_by = 112 + int'(lfsr_used);
         chk($sformatf("vec%0d_state", i), state, tbl[i].e_state);
         chk($sformatf("vec%0d_block_x", i), block_x, tbl[i].e_bx);
         chk($sformatf("vec%0d_player_y", i), player_y, tbl[i].e_py);
         chk($sformatf("vec%0d_block_y", i), block_y, exp_by);
         chk($sformatf("vec%0d_hit", i), saw_hit, 0);
         chk($sformatf("vec%0d_tick_pulse", i), tick, 0);
      end
      start = 1'b0;

      // Round 1: hold down, paddle clamps at Y_MAX, block wraps -> p1 scores
      run_round(1'b0, 1'b1, py400);
      chk("r1_clamp_ymax", py400, 469);
      chk("r1_p1", p1_score, 1);
      chk("r1_p2", p2_score, 0);
      chk("r1_state", state, 1);
      chk("r1_block_x", block_x, 0);
      chk("r1_player_y", player_y, 240);
      chk("r1_block_y", block_y, 112 + int'(lfsr_used));

      // Round 2: both buttons hold for 5 ticks, then up clamps at Y_MIN
      btn_up = 1'b1; btn_down = 1'b1;
      repeat (5) step_tick();
      chk("both_hold_py", player_y, 240);
      chk("both_hold_bx", block_x, 5);
      run_round(1'b1, 1'b0, py400);
      chk("r2_clamp_ymin", py400, 10);
      chk("r2_p1", p1_score, 2);
      chk("r2_state", state, 1);

      // Round 3: steer paddle onto the block lane -> collision at block_x=205
      exp_by = 112 + int'(lfsr_used);
      tgt    = exp_by + 5;
      n      = 0;
      do begin
         btn_down = (int'(player_y) < tgt - 1);
         btn_up   = (int'(player_y) > tgt + 1);
         step_tick();
         n++;
      end while (!saw_hit && n < 700);
      chk("col_seen", saw_hit, 1);
      chk("col_block_x_pre", pre_bx, 205);
      chk("col_hit_one_cycle", post_hit, 0);
      chk("col_state", state, 2);
      chk("col_block_x", block_x, 0);
      chk("col_player_y", player_y, 240);
      chk("col_block_y", block_y, 112 + int'(lfsr_used));
      chk("col_p1", p1_score, 2);
      chk("col_p2", p2_score, 0);

      // Player 2 dodges ten times; the tenth wrap wins and freezes the field
      for (int r = 1; r <= 10; r++) begin
         if (r == 10) start = 1'b1;
         exp_by = int'(block_y);
         run_round(1'b0, 1'b1, py400);
         chk($sformatf("p2r%0d_p2", r), p2_score, r);
         chk($sformatf("p2r%0d_p1", r), p1_score, 2);
         if (r < 10) begin
            chk($sformatf("p2r%0d_state", r), state, 2);
            chk($sformatf("p2r%0d_block_x", r), block_x, 0);
         end
      end
      chk("win_state", state, 3);
      chk("win_block_x", block_x, 639);
      chk("win_player_y", player_y, 469);
      chk("win_block_y", block_y, exp_by);

      // QDONE with start held: everything frozen, even with a button pressed
      btn_up = 1'b1; btn_down = 1'b0;
      repeat (3) step_tick();
      chk("done_state", state, 3);
      chk("done_block_x", block_x, 639);
      chk("done_player_y", player_y, 469);
      chk("done_p2", p2_score, 10);

      // Release start -> QI with scores kept; start again clears scores
      start = 1'b0;
      step_tick();
      chk("qi_state", state, 0);
      chk("qi_p1_kept", p1_score, 2);
      chk("qi_p2_kept", p2_score, 10);
      start = 1'b1; btn_up = 1'b0;
      step_tick();
      chk("restart_state", state, 1);
      chk("restart_p1", p1_score, 0);
      chk("restart_p2", p2_score, 0);
      chk("restart_block_x", block_x, 0);
      start = 1'b0;
      btn_down = 1'b1;
      repeat (3) step_tick();
      chk("pre_reset_block_x", block_x, 3);

      // Asynchronous reset mid-count, checked before any further clock edge
      @(posedge board_clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_player_y", player_y, 240);
      chk("arst_block_x", block_x, 0);
      chk("arst_block_y", block_y, 112);
      chk("arst_state", state, 0);
      chk("arst_p1", p1_score, 0);
      chk("arst_p2", p2_score, 0);
      chk("arst_tick", tick, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Game controller for the VGA dodge demo. Owns the player paddle position, the moving block, the two player scores and the turn state machine (QI, QGAME_1, QGAME_2, QDONE).
- All updates are paced by an internal frame-tick prescaler.
- Outputs feed the pixel-colour logic, the LD indicators and the SSD score display.
- Replaces the ad-hoc position logic in the top level.

Parameters:
TICK_DIV, 2097152, board_clk cycles per game tick (2^21, about 24 Hz at 50 MHz)
WIN_SCORE, 10, score that ends the game
PLAYER_Y_RST, 240, paddle centre Y after reset, turn change or launch
PLAYER_STEP, 2, paddle pixels moved per tick
PLAYER_X, 224, left column of paddle; paddle spans PLAYER_X..PLAYER_X+31
PLAYER_HALF, 10, paddle half-height; paddle spans player_y-10..player_y+10
Y_MIN, 10, lowest legal player_y
Y_MAX, 469, highest legal player_y
BLOCK_W, 20, block width; block spans block_x..block_x+19
BLOCK_H, 16, block height; block spans block_y..block_y+15
BLOCK_STEP, 1, block pixels moved per tick
X_MAX, 640, block wrap column
BLOCK_Y_BASE, 112, added to LFSR value to form block lane

Ports:
board_clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
start  in  1  level (Sw1); begins a game from QI
btn_up  in  1  paddle up, pre-debounced level
btn_down  in  1  paddle down, pre-debounced level
player_y  out  10  paddle centre Y
block_x  out  10  block left X
block_y  out  10  block top Y
p1_score  out  4  player 1 score, 0..WIN_SCORE
p2_score  out  4  player 2 score, 0..WIN_SCORE
state  out  2  00 QI, 01 QGAME_1, 10 QGAME_2, 11 QDONE
tick  out  1  one-cycle game-tick pulse
hit  out  1  one-cycle pulse on collision tick

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock board_clk. All registers are reset asynchronously and clocked on the board_clk rising edge.
- Reset values: player_y=PLAYER_Y_RST, block_x=0, block_y=BLOCK_Y_BASE, scores=0, state=QI, tick=0, hit=0, prescaler=0, LFSR=8'h01.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 exactly in the cycle the count equals TICK_DIV-1. All game registers update only when tick=1; otherwise they hold.
- LFSR: 8-bit maximal (taps 8,6,5,4) advancing every board_clk, never zero. "Launch" means block_x<=0, block_y<=BLOCK_Y_BASE+lfsr, player_y<=PLAYER_Y_RST.
- QI: on tick with start=1 -> launch, state QGAME_1, scores cleared.
- QGAME_1 / QGAME_2, on tick, in priority order:
  1. Collision, evaluated on pre-tick register values using 11-bit unsigned compares: block_x+BLOCK_W-1>=PLAYER_X and block_x<=PLAYER_X+31 and block_y+BLOCK_H-1>=player_y-PLAYER_HALF and block_y<=player_y+PLAYER_HALF. On collision: hit=1 for that cycle, state toggles QGAME_1<->QGAME_2, launch. No score change.
  2. Otherwise, if block_x+step>=X_MAX: the active player's score increments. If the new score equals WIN_SCORE -> QDONE, all positions hold. Otherwise launch, state unchanged.
  3. Otherwise: block_x+=step.
- Paddle motion applies in the same tick only when case 3 applies:
  - btn_down only: player_y+=PLAYER_STEP, clamped to Y_MAX.
  - btn_up only: player_y-=PLAYER_STEP, clamped to Y_MIN.
  - Both or neither pressed: hold.
- QDONE: scores and positions frozen. On tick with start=0 -> QI; scores persist until the next start.
- start deasserted during QGAME_x has no effect.
- Reset mid-game returns all registers to reset values immediately, without waiting for a tick.
- Scores saturate at WIN_SCORE and never wrap.

Optional Feature:
- Macro: GAME_SPEEDUP_EN.
- Defined: the block step is 1+(active score/3), capped at 4, and is used for both the motion and the wrap compare.
- Undefined: the step is the constant BLOCK_STEP.

Test Plan:
- Reset check (TICK_DIV=4 in all tests): assert reset mid-count -> same cycle: player_y=240, block_x=0, block_y=112, state=00, scores=0, tick=0.
- Start and move: start=1 -> state=01 after first tick; block_x=1,2,3 on following ticks. btn_down held 300 ticks without collision -> player_y clamps at 469.
- Both buttons pressed for 5 ticks -> player_y unchanged.
- Dodge: force player_y=460, lanes 113..367 -> block reaches 639, next tick p1_score=1, block_x=0, state stays 01.
- Collision: player_y=block_y+5 at block_x=205 -> hit pulses 1 cycle, state=10, block_x=0, player_y=240, scores unchanged.
- Win: preload p2_score=9 in QGAME_2 and let the block wrap -> p2_score=10, state=11, positions frozen. start=0 -> state=00 on next tick.
